// File: rtl/instr_encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder_pkg
// Purpose  : Shared definitions for the instruction encoder: descriptor
//            operation codes, MIPS primary opcode / funct constants, FIFO
//            depth and the controller state encoding.
// Config   : ENC_RANGE_CHECK_EN (used by instr_encode_word) enables
//            immediate range checking.
// Revision : 1.0 - initial release
// ============================================================================
package instr_encoder_pkg;

   // Descriptor operation codes (in_op); 13..15 are illegal
   localparam logic [3:0] ENC_OP_ADDU    = 4'd0;
   localparam logic [3:0] ENC_OP_SUBU    = 4'd1;
   localparam logic [3:0] ENC_OP_SLL     = 4'd2;
   localparam logic [3:0] ENC_OP_JR      = 4'd3;
   localparam logic [3:0] ENC_OP_SYSCALL = 4'd4;
   localparam logic [3:0] ENC_OP_ADDIU   = 4'd5;
   localparam logic [3:0] ENC_OP_ORI     = 4'd6;
   localparam logic [3:0] ENC_OP_LW      = 4'd7;
   localparam logic [3:0] ENC_OP_SW      = 4'd8;
   localparam logic [3:0] ENC_OP_BEQ     = 4'd9;
   localparam logic [3:0] ENC_OP_LUI     = 4'd10;
   localparam logic [3:0] ENC_OP_JAL     = 4'd11;
   localparam logic [3:0] ENC_OP_J       = 4'd12;

   // MIPS primary opcodes
   localparam logic [5:0] OPC_SPECIAL = 6'h00;
   localparam logic [5:0] OPC_J       = 6'h02;
   localparam logic [5:0] OPC_JAL     = 6'h03;
   localparam logic [5:0] OPC_BEQ     = 6'h04;
   localparam logic [5:0] OPC_ADDIU   = 6'h09;
   localparam logic [5:0] OPC_ORI     = 6'h0D;
   localparam logic [5:0] OPC_LUI     = 6'h0F;
   localparam logic [5:0] OPC_LW      = 6'h23;
   localparam logic [5:0] OPC_SW      = 6'h2B;

   // MIPS SPECIAL funct codes
   localparam logic [5:0] FUNCT_SLL     = 6'h00;
   localparam logic [5:0] FUNCT_JR      = 6'h08;
   localparam logic [5:0] FUNCT_SYSCALL = 6'h0C;
   localparam logic [5:0] FUNCT_ADDU    = 6'h21;
   localparam logic [5:0] FUNCT_SUBU    = 6'h23;

   // Output FIFO depth (occupancy counter is 2 bits)
   localparam logic [1:0] FIFO_DEPTH = 2'd2;

   // Controller state encoding
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } enc_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_encode_word.sv
`default_nettype none
// ============================================================================
// Module   : instr_encode_word
// Purpose  : Purely combinational translation of one descriptor into a
//            32-bit MIPS instruction word, with legality / range flags.
// Ports    : op, rs, rt, rd, imm  - descriptor fields
//            word                 - encoded instruction
//            illegal              - op is not a defined ENC_OP_* code
//            range_err            - immediate does not fit the field
// Config   : ENC_RANGE_CHECK_EN - when defined, range_err flags immediates
//            with excess significant bits; otherwise range_err is 0 and the
//            excess bits are simply truncated.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encode_word
   import instr_encoder_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [25:0] imm,
   output logic [31:0] word,
   output logic        illegal,
   output logic        range_err
);

   always_comb begin
      word    = 32'h0000_0000;
      illegal = 1'b0;
      case (op)
         ENC_OP_ADDU:    word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_ADDU};
         ENC_OP_SUBU:    word = {OPC_SPECIAL, rs, rt, rd, 5'd0, FUNCT_SUBU};
         ENC_OP_SLL:     word = {OPC_SPECIAL, 5'd0, rt, rd, imm[4:0], FUNCT_SLL};
         ENC_OP_JR:      word = {OPC_SPECIAL, rs, 15'd0, FUNCT_JR};
         ENC_OP_SYSCALL: word = {26'd0, FUNCT_SYSCALL};
         ENC_OP_ADDIU:   word = {OPC_ADDIU, rs, rt, imm[15:0]};
         ENC_OP_ORI:     word = {OPC_ORI,   rs, rt, imm[15:0]};
         ENC_OP_LW:      word = {OPC_LW,    rs, rt, imm[15:0]};
         ENC_OP_SW:      word = {OPC_SW,    rs, rt, imm[15:0]};
         ENC_OP_BEQ:     word = {OPC_BEQ,   rs, rt, imm[15:0]};
         ENC_OP_LUI:     word = {OPC_LUI,   rs, rt, imm[15:0]};
         ENC_OP_JAL:     word = {OPC_JAL,   imm};
         ENC_OP_J:       word = {OPC_J,     imm};
         default:        illegal = 1'b1;
      endcase
   end

`ifdef ENC_RANGE_CHECK_EN
   // Zero-extended fields need clear upper bits; sign-extended fields need
   // the upper bits to replicate bit 15; the shift amount is 5 bits wide.
   always_comb begin
      range_err = 1'b0;
      case (op)
         ENC_OP_ORI, ENC_OP_LUI:
            range_err = (imm[25:16] != 10'd0);
         ENC_OP_ADDIU, ENC_OP_LW, ENC_OP_SW, ENC_OP_BEQ:
            range_err = (imm[25:16] != {10{imm[15]}});
         ENC_OP_SLL:
            range_err = (imm[25:5] != 21'd0);
         default:
            range_err = 1'b0;
      endcase
   end
`else
   assign range_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
// Module   : instr_encoder
// Purpose  : Program loader that encodes a stream of instruction
//            descriptors into MIPS words and writes them to consecutive
//            instruction-memory addresses through a 2-entry FIFO.
// Ports    : clk, reset (async, active high)
//            start, base_addr                 - begin a load (IDLE only)
//            in_valid/in_ready, in_op, in_rs, in_rt, in_rd, in_imm
//                                             - descriptor handshake
//            imem_we, imem_addr, imem_wdata, imem_ready
//                                             - memory write port
//            busy, done, words_written        - status
//            err_illegal, err_range           - sticky error flags
// Config   : ENC_RANGE_CHECK_EN (see instr_encode_word) enables immediate
//            range checking; err_range stays 0 otherwise.
// Revision : 1.0 - initial release
// ============================================================================
module instr_encoder
   import instr_encoder_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [9:0]  base_addr,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [3:0]  in_op,
   input  logic [4:0]  in_rs,
   input  logic [4:0]  in_rt,
   input  logic [4:0]  in_rd,
   input  logic [25:0] in_imm,
   output logic        imem_we,
   output logic [9:0]  imem_addr,
   output logic [31:0] imem_wdata,
   input  logic        imem_ready,
   output logic        busy,
   output logic        done,
   output logic [10:0] words_written,
   output logic        err_illegal,
   output logic        err_range
);

   enc_state_t  r_state;
   enc_state_t  w_state_next;

   logic [31:0] r_fifo [0:1];
   logic        r_wr_ptr;
   logic        r_rd_ptr;
   logic [1:0]  r_count;

   logic [9:0]  r_addr;
   logic [10:0] r_words;
   logic        r_err_illegal;
   logic        r_err_range;

   logic [31:0] w_word;
   logic        w_illegal;
   logic        w_range_err;
   logic        w_in_ready;
   logic        w_done;
   logic        w_start_ok;
   logic        w_accept;
   logic        w_push;
   logic        w_pop;

   instr_encode_word u_encode (
      .op        (in_op),
      .rs        (in_rs),
      .rt        (in_rt),
      .rd        (in_rd),
      .imm       (in_imm),
      .word      (w_word),
      .illegal   (w_illegal),
      .range_err (w_range_err)
   );

   // ---------------------------------------------------------------------
   // Controller: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------------------------------------------------------------
   // Controller: next state and outputs. in_ready depends only on state
   // and occupancy, never on in_valid. done is raised in the DRAIN cycle
   // that finds the FIFO empty, so a coincident start still sees DRAIN
   // and is ignored.
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_done       = 1'b0;
      w_start_ok   = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start_ok   = 1'b1;
               w_state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            w_in_ready = (r_count != FIFO_DEPTH);
            if (in_valid && w_in_ready && (in_op == ENC_OP_SYSCALL)) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (r_count == 2'd0) begin
               w_done       = 1'b1;
               w_state_next = ST_IDLE;
            end
         end
         default: begin
            w_state_next = ST_IDLE;
         end
      endcase
   end

   // Illegal or out-of-range descriptors are consumed but never buffered
   assign w_accept = in_valid && w_in_ready;
   assign w_push   = w_accept && !w_illegal && !w_range_err;
   assign w_pop    = (r_count != 2'd0) && imem_ready;

   // ---------------------------------------------------------------------
   // FIFO, address / word counter and sticky error flags
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fifo[0]     <= 32'h0000_0000;
         r_fifo[1]     <= 32'h0000_0000;
         r_wr_ptr      <= 1'b0;
         r_rd_ptr      <= 1'b0;
         r_count       <= 2'd0;
         r_addr        <= 10'd0;
         r_words       <= 11'd0;
         r_err_illegal <= 1'b0;
         r_err_range   <= 1'b0;
      end else begin
         if (w_push) begin
            r_fifo[r_wr_ptr] <= w_word;
            r_wr_ptr         <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         // Simultaneous push and pop keeps the occupancy unchanged
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase

         // The FIFO is always empty in IDLE, so a start never races a pop
         if (w_start_ok) begin
            r_addr        <= base_addr;
            r_words       <= 11'd0;
            r_err_illegal <= 1'b0;
            r_err_range   <= 1'b0;
         end else begin
            if (w_pop) begin
               r_addr  <= r_addr + 10'd1;   // wraps 1023 -> 0
               r_words <= r_words + 11'd1;
            end
            if (w_accept && w_illegal) begin
               r_err_illegal <= 1'b1;
            end
            if (w_accept && w_range_err) begin
               r_err_range <= 1'b1;
            end
         end
      end
   end

   assign in_ready      = w_in_ready;
   assign imem_we       = (r_count != 2'd0);
   assign imem_addr     = r_addr;
   assign imem_wdata    = r_fifo[r_rd_ptr];
   assign busy          = (r_state != ST_IDLE);
   assign done          = w_done;
   assign words_written = r_words;
   assign err_illegal   = r_err_illegal;
   assign err_range     = r_err_range;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_encoder
// Purpose  : Directed self-checking bench for instr_encoder. Expected
//            instruction words are hand-encoded constants.
// Config   : honours ENC_RANGE_CHECK_EN for the out-of-range expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;
   import instr_encoder_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [9:0]  base_addr;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_op;
   logic [4:0]  in_rs, in_rt, in_rd;
   logic [25:0] in_imm;
   logic        imem_we;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata;
   logic        imem_ready;
   logic        busy, done;
   logic [10:0] words_written;
   logic        err_illegal, err_range;

   int n_checks = 0;
   int n_pass   = 0;

   // Write log and done-pulse counter, sampled mid-cycle
   logic [9:0]  q_addr[$];
   logic [31:0] q_data[$];
   int          done_cnt = 0;

   always #5 clk = ~clk;

   instr_encoder dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .base_addr     (base_addr),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_op         (in_op),
      .in_rs         (in_rs),
      .in_rt         (in_rt),
      .in_rd         (in_rd),
      .in_imm        (in_imm),
      .imem_we       (imem_we),
      .imem_addr     (imem_addr),
      .imem_wdata    (imem_wdata),
      .imem_ready    (imem_ready),
      .busy          (busy),
      .done          (done),
      .words_written (words_written),
      .err_illegal   (err_illegal),
      .err_range     (err_range)
   );

   always @(negedge clk) begin
      if (imem_we && imem_ready) begin
         q_addr.push_back(imem_addr);
         q_data.push_back(imem_wdata);
      end
      if (done) done_cnt++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [9:0] a);
      start     = 1'b1;
      base_addr = a;
      tick();
      start     = 1'b0;
   endtask

   // Present one descriptor and hold it until accepted (bounded)
   task automatic send(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [25:0] imm);
      int waited = 0;
      in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd; in_imm = imm;
      while (!in_ready && waited < 40) begin
         tick();
         waited++;
      end
      n_checks++;
      if (in_ready !== 1'b1) $display("FAIL send_accept op=%0d: in_ready got %b required 1", op, in_ready);
      else n_pass++;
      tick();
      in_valid = 1'b0;
   endtask

   // Wait (bounded) for done; optionally pulse start in the done cycle
   task automatic wait_done(input bit poke_start);
      int waited = 0;
      while (done !== 1'b1 && waited < 60) begin
         tick();
         waited++;
      end
      n_checks++;
      if (done !== 1'b1) $display("FAIL done_timeout: done got %b required 1", done);
      else n_pass++;
      if (poke_start) begin
         start     = 1'b1;
         base_addr = 10'h2AA;
      end
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      n_checks++; if (imem_we !== 1'b0) $display("FAIL rst_we: got %b required 0", imem_we); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else n_pass++;
      n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b required 0", done); else n_pass++;
      n_checks++; if (words_written !== 11'd0) $display("FAIL rst_words: got %0d required 0", words_written); else n_pass++;
      n_checks++; if ({err_illegal, err_range} !== 2'b00) $display("FAIL rst_err: got %b required 00", {err_illegal, err_range}); else n_pass++;
      n_checks++; if (imem_addr !== 10'd0) $display("FAIL rst_addr: got %h required 000", imem_addr); else n_pass++;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_single();
      do_start(10'h010);
      n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b required 1", busy); else n_pass++;
      n_checks++; if (in_ready !== 1'b1) $display("FAIL single_in_ready: got %b required 1", in_ready); else n_pass++;
      do_start(10'h155);   // must be ignored outside IDLE
      send(ENC_OP_ADDU, 5'd1, 5'd2, 5'd3, 26'd0);
      n_checks++; if (imem_we !== 1'b1) $display("FAIL single_we: got %b required 1", imem_we); else n_pass++;
      n_checks++; if (imem_wdata !== 32'h00221821) $display("FAIL single_wdata: got %h required 00221821", imem_wdata); else n_pass++;
      n_checks++; if (imem_addr !== 10'h010) $display("FAIL single_addr: got %h required 010", imem_addr); else n_pass++;
      send(ENC_OP_SYSCALL, 5'd0, 5'd0, 5'd0, 26'd0);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL single_drain_ready: got %b required 0", in_ready); else n_pass++;
      wait_done(1'b0);
      n_checks++; if (words_written !== 11'd2) $display("FAIL single_words: got %0d required 2", words_written); else n_pass++;
   endtask

   task automatic test_stream();
      logic [31:0] exp_d [6];
      logic [9:0]  ea;
      int qb, db;
      exp_d = '{32'h00052080, 32'h34011234, 32'h2408FFFF, 32'h8FA20004, 32'h0C000100, 32'h0000000C};
      qb = q_data.size();
      db = done_cnt;
      do_start(10'h010);
      send(ENC_OP_SLL,     5'd0,  5'd5, 5'd4, 26'd2);
      send(ENC_OP_ORI,     5'd0,  5'd1, 5'd0, 26'h1234);
      send(ENC_OP_ADDIU,   5'd0,  5'd8, 5'd0, 26'h3FFFFFF);
      send(ENC_OP_LW,      5'd29, 5'd2, 5'd0, 26'd4);
      send(ENC_OP_JAL,     5'd0,  5'd0, 5'd0, 26'h100);
      send(ENC_OP_SYSCALL, 5'd0,  5'd0, 5'd0, 26'd0);
      wait_done(1'b1);     // start in the done cycle must be ignored
      tick();
      n_checks++; if (busy !== 1'b0) $display("FAIL stream_start_on_done: busy got %b required 0", busy); else n_pass++;
      n_checks++; if (done_cnt - db !== 1) $display("FAIL stream_done_pulses: got %0d required 1", done_cnt - db); else n_pass++;
      n_checks++; if (words_written !== 11'd6) $display("FAIL stream_words: got %0d required 6", words_written); else n_pass++;
      n_checks++; if (q_data.size() - qb !== 6) $display("FAIL stream_count: got %0d required 6", q_data.size() - qb); else n_pass++;
      for (int i = 0; i < 6; i++) begin
         ea = 10'h010 + i[9:0];
         n_checks++;
         if (q_data.size() <= qb + i) $display("FAIL stream_word%0d: missing, required %h@%h", i, exp_d[i], ea);
         else if (q_data[qb+i] !== exp_d[i] || q_addr[qb+i] !== ea)
            $display("FAIL stream_word%0d: got %h@%h required %h@%h", i, q_data[qb+i], q_addr[qb+i], exp_d[i], ea);
         else n_pass++;
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_d [3];
      int qb;
      bit stable;
      exp_d = '{32'h00221821, 32'h00853023, 32'h0000000C};
      qb = q_data.size();
      imem_ready = 1'b0;
      do_start(10'h020);
      send(ENC_OP_ADDU, 5'd1, 5'd2, 5'd3, 26'd0);
      send(ENC_OP_SUBU, 5'd4, 5'd5, 5'd6, 26'd0);
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready: got %b required 0", in_ready); else n_pass++;
      stable = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (imem_we !== 1'b1 || imem_wdata !== 32'h00221821 || imem_addr !== 10'h020 || in_ready !== 1'b0) stable = 1'b0;
         tick();
      end
      n_checks++;
      if (!stable || imem_wdata !== 32'h00221821 || imem_addr !== 10'h020)
         $display("FAIL bp_hold: got %h@%h required 00221821@020 held", imem_wdata, imem_addr);
      else n_pass++;
      imem_ready = 1'b1;
      send(ENC_OP_SYSCALL, 5'd0, 5'd0, 5'd0, 26'd0);
      wait_done(1'b0);
      n_checks++; if (words_written !== 11'd3) $display("FAIL bp_words: got %0d required 3", words_written); else n_pass++;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (q_data.size() <= qb + i) $display("FAIL bp_word%0d: missing, required %h", i, exp_d[i]);
         else if (q_data[qb+i] !== exp_d[i] || q_addr[qb+i] !== 10'h020 + i[9:0])
            $display("FAIL bp_word%0d: got %h@%h required %h@%h", i, q_data[qb+i], q_addr[qb+i], exp_d[i], 10'h020 + i[9:0]);
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      logic [9:0]  exp_a [3];
      logic [31:0] exp_d [3];
      int qb;
      exp_a = '{10'h3FF, 10'h000, 10'h001};
      exp_d = '{32'h00221821, 32'h00853021, 32'h0000000C};
      qb = q_data.size();
      do_start(10'h3FF);
      send(ENC_OP_ADDU, 5'd1, 5'd2, 5'd3, 26'd0);
      send(ENC_OP_ADDU, 5'd4, 5'd5, 5'd6, 26'd0);
      send(ENC_OP_SYSCALL, 5'd0, 5'd0, 5'd0, 26'd0);
      wait_done(1'b0);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (q_data.size() <= qb + i) $display("FAIL wrap_word%0d: missing, required %h@%h", i, exp_d[i], exp_a[i]);
         else if (q_data[qb+i] !== exp_d[i] || q_addr[qb+i] !== exp_a[i])
            $display("FAIL wrap_word%0d: got %h@%h required %h@%h", i, q_data[qb+i], q_addr[qb+i], exp_d[i], exp_a[i]);
         else n_pass++;
      end
   endtask

   task automatic test_illegal();
      do_start(10'h040);
      send(4'd14, 5'd1, 5'd2, 5'd3, 26'd0);
      n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_flag: got %b required 1", err_illegal); else n_pass++;
      n_checks++; if (imem_we !== 1'b0) $display("FAIL ill_no_write: imem_we got %b required 0", imem_we); else n_pass++;
      send(ENC_OP_ORI, 5'd0, 5'd0, 5'd0, 26'h10000);
`ifdef ENC_RANGE_CHECK_EN
      n_checks++; if (err_range !== 1'b1) $display("FAIL range_flag: got %b required 1", err_range); else n_pass++;
      n_checks++; if (imem_we !== 1'b0) $display("FAIL range_no_write: imem_we got %b required 0", imem_we); else n_pass++;
`else
      n_checks++; if (err_range !== 1'b0) $display("FAIL range_flag: got %b required 0", err_range); else n_pass++;
      n_checks++; if (imem_we !== 1'b1 || imem_wdata !== 32'h34000000)
         $display("FAIL range_trunc: got we=%b %h required we=1 34000000", imem_we, imem_wdata); else n_pass++;
`endif
      send(ENC_OP_SYSCALL, 5'd0, 5'd0, 5'd0, 26'd0);
      wait_done(1'b0);
      n_checks++; if (err_illegal !== 1'b1) $display("FAIL ill_sticky: got %b required 1", err_illegal); else n_pass++;
`ifdef ENC_RANGE_CHECK_EN
      n_checks++; if (words_written !== 11'd1) $display("FAIL ill_words: got %0d required 1", words_written); else n_pass++;
`else
      n_checks++; if (words_written !== 11'd2) $display("FAIL ill_words: got %0d required 2", words_written); else n_pass++;
`endif
      do_start(10'h070);
      n_checks++; if ({err_illegal, err_range} !== 2'b00) $display("FAIL err_clear: got %b required 00", {err_illegal, err_range}); else n_pass++;
      n_checks++; if (words_written !== 11'd0) $display("FAIL words_clear: got %0d required 0", words_written); else n_pass++;
      send(ENC_OP_SYSCALL, 5'd0, 5'd0, 5'd0, 26'd0);
      wait_done(1'b0);
   endtask

   task automatic test_reset_midload();
      int qs;
      imem_ready = 1'b0;
      do_start(10'h050);
      send(ENC_OP_ADDU, 5'd1, 5'd2, 5'd3, 26'd0);
      send(ENC_OP_SUBU, 5'd4, 5'd5, 5'd6, 26'd0);
      n_checks++; if (imem_we !== 1'b1 || in_ready !== 1'b0) $display("FAIL mid_full: got we=%b rdy=%b required we=1 rdy=0", imem_we, in_ready); else n_pass++;
      qs = q_data.size();
      reset = 1'b1;
      #1;
      n_checks++; if (imem_we !== 1'b0) $display("FAIL mid_rst_we: got %b required 0", imem_we); else n_pass++;
      n_checks++; if ({busy, done, in_ready} !== 3'b000) $display("FAIL mid_rst_ctl: got %b required 000", {busy, done, in_ready}); else n_pass++;
      n_checks++; if (words_written !== 11'd0 || imem_addr !== 10'd0) $display("FAIL mid_rst_cnt: got %0d@%h required 0@000", words_written, imem_addr); else n_pass++;
      imem_ready = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick(); tick();
      n_checks++; if (q_data.size() !== qs || imem_we !== 1'b0) $display("FAIL mid_no_write: got %0d writes we=%b required 0 we=0", q_data.size() - qs, imem_we); else n_pass++;
      do_start(10'h060);
      send(ENC_OP_ADDU, 5'd1, 5'd2, 5'd3, 26'd0);
      n_checks++; if (imem_wdata !== 32'h00221821 || imem_addr !== 10'h060)
         $display("FAIL post_rst_word: got %h@%h required 00221821@060", imem_wdata, imem_addr); else n_pass++;
      send(ENC_OP_SYSCALL, 5'd0, 5'd0, 5'd0, 26'd0);
      wait_done(1'b0);
      n_checks++; if (words_written !== 11'd2) $display("FAIL post_rst_words: got %0d required 2", words_written); else n_pass++;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; base_addr = 10'd0; in_valid = 1'b0;
      in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 26'd0;
      imem_ready = 1'b1;
      test_reset();
      test_single();
      test_stream();
      test_backpressure();
      test_wrap();
      test_illegal();
      test_reset_midload();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1);
   end

endmodule
`default_nettype wire
